// File: rtl/lcd_frame_scheduler.sv
// Double-buffered frame RAM bank control and LCD driver refresh sequencing.
// Refreshes come from a free-running tick or a commit; a commit swaps the displayed bank before its refresh.
module lcd_frame_scheduler #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT        = 4096
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       commit_i,
    input  logic       wr_en_i,
    input  logic [9:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       b0_we_o,
    output logic       b1_we_o,
    output logic [9:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    input  logic [9:0] drv_addr_i,
    input  logic [7:0] b0_rdata_i,
    input  logic [7:0] b1_rdata_i,
    output logic [7:0] drv_data_o,
    output logic       start_o,
    output logic       front_sel_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       timeout_o
);

    localparam int TICK_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int CNT_MAX = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWAP,
        ST_START,
        ST_RUN
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [CNT_W-1:0]    r_cnt;
    logic [9:0]          r_prev_addr;
    logic                r_refresh_req;
    logic                r_commit_pend;
    logic                r_start;
    logic                r_front_sel;
    logic                r_busy;
    logic                r_overrun;
    logic                r_timeout;

    logic                w_tick_last;
    logic                w_refresh;
    logic                w_done;
    logic                w_in_swap;
    logic                w_idle_to_start;

    // A tick landing in the same cycle IDLE is checked starts the refresh at once.
    assign w_tick_last     = (r_tick == TICK_LAST);
    assign w_refresh       = r_refresh_req | w_tick_last;
    assign w_done          = (r_prev_addr == 10'h3FF) && (drv_addr_i == 10'h000);
    assign w_in_swap       = (r_state == ST_SWAP);
    assign w_idle_to_start = (r_state == ST_IDLE) && !r_commit_pend && w_refresh;

    // Writes follow the registered bank select, so a write during SWAP lands in the old back bank.
    assign b0_we_o     = wr_en_i & r_front_sel;
    assign b1_we_o     = wr_en_i & ~r_front_sel;
    assign wr_addr_o   = wr_addr_i;
    assign wr_data_o   = wr_data_i;
    assign drv_data_o  = r_front_sel ? b1_rdata_i : b0_rdata_i;

    assign start_o     = r_start;
    assign front_sel_o = r_front_sel;
    assign busy_o      = r_busy;
    assign overrun_o   = r_overrun;
    assign timeout_o   = r_timeout;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tick      <= '0;
            r_prev_addr <= '0;
        end else begin
            r_tick      <= w_tick_last ? '0 : r_tick + 1'b1;
            r_prev_addr <= drv_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_refresh_req <= 1'b0;
            r_commit_pend <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_in_swap || w_idle_to_start) begin
                r_refresh_req <= 1'b0;
            end else if (w_tick_last) begin
                r_refresh_req <= 1'b1;
            end
            r_commit_pend <= commit_i | (r_commit_pend & ~w_in_swap);
            if (commit_i && r_commit_pend && !w_in_swap) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_front_sel <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_commit_pend) begin
                        r_state <= ST_SWAP;
                        r_busy  <= 1'b1;
                    end else if (w_refresh) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_SWAP: begin
                    r_front_sel <= ~r_front_sel;
                    r_state     <= ST_START;
                    r_start     <= 1'b1;
                    r_cnt       <= '0;
                end
                ST_START: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_start <= 1'b0;
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == RUN_LAST) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboarded bench: stimulus schedules refreshes and pushes expected records; a driver/monitor
// process acts as the LCD driver, pops a record at every start pulse and compares the observed refresh.
module tb_lcd_frame_scheduler;

    localparam int REFRESH = 100;
    localparam int HOLD    = 4;
    localparam int TMO     = 50;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       commit_i = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       b0_we, b1_we;
    logic [9:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [9:0] drv_addr = '0;
    logic [7:0] b0_rdata, b1_rdata, drv_data;
    logic       start_o, front_sel, busy, overrun, timeout;

    logic       init_req = 1'b1;
    logic [7:0] ram0 [1024];
    logic [7:0] ram1 [1024];
    int         cyc;

    typedef struct {
        int         start;
        bit         front;
        bit         stall;
        bit         abort;
        int         exp_len;
        bit         exp_to;
        bit         exp_ov;
        logic [9:0] paddr;
        logic [7:0] pdata;
    } rec_t;

    rec_t       sb[$];
    logic [9:0] wlist[$];
    logic [7:0] img [2][1024];
    bit         model_front;
    int         nchecks = 0;
    int         npass = 0;
    int         done_cnt = 0;

    lcd_frame_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .START_HOLD    (HOLD),
        .TIMEOUT       (TMO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .commit_i   (commit_i),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .b0_we_o    (b0_we),
        .b1_we_o    (b1_we),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .drv_addr_i (drv_addr),
        .b0_rdata_i (b0_rdata),
        .b1_rdata_i (b1_rdata),
        .drv_data_o (drv_data),
        .start_o    (start_o),
        .front_sel_o(front_sel),
        .busy_o     (busy),
        .overrun_o  (overrun),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    // Frame RAM banks behind the scheduler.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) begin
                ram0[i] <= 8'(i * 7 + 3);
                ram1[i] <= 8'(i * 13 + 1);
            end
        end else begin
            if (b0_we) ram0[wr_addr_o] <= wr_data_o;
            if (b1_we) ram1[wr_addr_o] <= wr_data_o;
        end
    end
    assign b0_rdata = ram0[drv_addr];
    assign b1_rdata = ram1[drv_addr];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    endtask

    function automatic logic [9:0] rnd_addr();
        return 10'($urandom_range(0, 1022));
    endfunction

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("schedule", cyc, n);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check("b0_we", b0_we, {31'b0, model_front});
        check("b1_we", b1_we, {31'b0, ~model_front});
        check("wr_addr_o", wr_addr_o, a);
        check("wr_data_o", wr_data_o, d);
        img[~model_front][a] = d;
        wlist.push_back(a);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic commit_at(input int c);
        wait_cyc(c);
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
    endtask

    task automatic push(input int start, input bit swap, input bit stall, input bit abort,
                        input int exp_len, input bit to, input bit ov, input int force_addr);
        rec_t r;
        if (swap) model_front = ~model_front;
        r.start   = start;
        r.front   = model_front;
        r.stall   = stall;
        r.abort   = abort;
        r.exp_len = exp_len;
        r.exp_to  = to;
        r.exp_ov  = ov;
        if (force_addr >= 0) r.paddr = 10'(force_addr);
        else if (wlist.size() > 0 && $urandom_range(0, 1) == 1)
            r.paddr = wlist[$urandom_range(0, wlist.size() - 1)];
        else r.paddr = rnd_addr();
        r.pdata = img[model_front][r.paddr];
        sb.push_back(r);
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++) do_write(rnd_addr(), 8'($urandom));
    endtask

    // LCD driver model plus monitor.
    initial begin : monitor
        rec_t r;
        int   n;
        int   run_len;
        int   gap;
        int   exp_len;
        @(posedge rstn);
        forever begin
            n = 0;
            while (n < 400) begin
                @(negedge clk);
                if (rstn && start_o) break;
                drv_addr = (n == 0) ? 10'h3FF : (n == 1) ? 10'h000 : rnd_addr();
                n++;
            end
            drv_addr = rnd_addr();
            if (n >= 400) begin
                check("start_wait_bound", 32'(n), 32'(0));
                continue;
            end
            check("queue_entry", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() == 0) begin
                n = 0;
                while (start_o && n < 100) begin @(negedge clk); n++; end
                continue;
            end
            r = sb.pop_front();
            if (r.start >= 0) check("start_cycle", cyc, r.start);
            check("front_sel", front_sel, {31'b0, r.front});
            n = 1;
            while (n < 100) begin
                @(negedge clk);
                if (!rstn || !start_o) break;
                n++;
            end
            check("start_hold", n, HOLD);
            check("busy_in_run", busy, 32'd1);
            run_len = 1;
            drv_addr = r.paddr;
            #1;
            check("probe_data", drv_data, r.pdata);
            gap = $urandom_range(2, 20);
            while (run_len < 200) begin
                @(negedge clk);
                if (!rstn || !busy) break;
                run_len++;
                if (r.stall || run_len <= gap + 1) drv_addr = rnd_addr();
                else if (run_len == gap + 2)     drv_addr = 10'h3FF;
                else                             drv_addr = 10'h000;
            end
            exp_len = (r.exp_len >= 0) ? r.exp_len : gap + 3;
            check("run_len", run_len, exp_len);
            if (!r.abort) begin
                check("timeout_flag", timeout, {31'b0, r.exp_to});
                check("overrun_flag", overrun, {31'b0, r.exp_ov});
            end
            done_cnt++;
        end
    end

    initial begin : stimulus
        logic [9:0] a;
        logic [7:0] d;
        for (int i = 0; i < 1024; i++) begin
            img[0][i] = 8'(i * 7 + 3);
            img[1][i] = 8'(i * 13 + 1);
        end
        model_front = 1'b0;
        repeat (4) @(negedge clk);
        init_req = 1'b0;
        check("rst_start", start_o, 32'd0);
        check("rst_front", front_sel, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_overrun", overrun, 32'd0);
        check("rst_timeout", timeout, 32'd0);
        rstn = 1'b1;

        // Periodic refresh right after reset, then a committed frame.
        push(100, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_cyc(150);
        rand_writes(9);
        do_write(10'd5, 8'hA5);
        commit_at(160);
        check("pend_idle_busy", busy, 32'd0);
        wait_cyc(162);
        push(163, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 5);
        a = 10'($urandom_range(6, 1022));
        d = 8'($urandom);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check("swap_b1_we", b1_we, 32'd1);
        check("swap_b0_we", b0_we, 32'd0);
        check("swap_busy", busy, 32'd1);
        check("swap_front_old", front_sel, 32'd0);
        img[1][a] = d;
        @(negedge clk);
        wr_en = 1'b0;
        check("swap_front_new", front_sel, 32'd1);

        // Double commit during RUN: overrun, exactly one swap afterwards.
        wait_cyc(190);
        push(200, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        commit_at(205);
        check("overrun_single", overrun, 32'd0);
        commit_at(206);
        check("overrun_double", overrun, 32'd1);
        push(-1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);

        // Stalled driver: timeout, then normal restart on the next tick.
        wait_cyc(260);
        push(300, 1'b0, 1'b1, 1'b0, TMO, 1'b1, 1'b1, -1);
        wait_cyc(360);
        check("timeout_sticky", timeout, 32'd1);
        push(400, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, -1);

        // Commit during START is held until that refresh completes.
        wait_cyc(440);
        rand_writes(10);
        push(500, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, -1);
        commit_at(501);
        push(-1, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b1, -1);

        // Commit in the very cycle IDLE leaves for a tick refresh.
        wait_cyc(570);
        rand_writes(10);
        push(600, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, -1);
        commit_at(599);
        push(-1, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b1, -1);

        // Reset in the middle of RUN while bank 1 is displayed.
        wait_cyc(664);
        push(668, 1'b1, 1'b1, 1'b1, 682 - (668 + HOLD) + 1, 1'b0, 1'b0, -1);
        commit_at(665);
        wait_cyc(682);
        check("pre_rst_front", front_sel, 32'd1);
        check("pre_rst_busy", busy, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_front", front_sel, 32'd0);
        check("async_rst_start", start_o, 32'd0);
        check("async_rst_busy", busy, 32'd0);
        check("async_rst_overrun", overrun, 32'd0);
        check("async_rst_timeout", timeout, 32'd0);
        repeat (3) @(negedge clk);
        model_front = 1'b0;
        rstn = 1'b1;
        push(100, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_cyc(180);
        check("refresh_count", done_cnt, 12);
        check("queue_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
